comparator_2b_checker: RTL and testbench

- Synthesizable self-checking stimulus/response engine for the 2-bit magnitude comparator.
- Drives all 16 {A1,A0,B1,B0} combinations in ascending order and holds each for a settle window.
- Samples the DUT's F1/F2/F3 at the end of each window and checks them against the expected result.
- Reports pass/fail, a saturating error count and the first failing vector, so the comparator can be checked on-chip or in a harness with no testbench logic.

---
 rtl/comparator_2b_checker.sv | 126 ++++++++++++
 tb/tb_comparator_2b_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_2b_checker.sv
// Self-checking stimulus/response engine for a 2-bit magnitude comparator.
// Sweeps all 16 {A1,A0,B1,B0} vectors, holds each for DWELL cycles, samples
// F1/F2/F3 in the last cycle of each window and accumulates results.
// Optional build macro: CMP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module comparator_2b_checker #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             F1,
  input  logic             F2,
  input  logic             F3,
  output logic             A1,
  output logic             A0,
  output logic             B1,
  output logic             B0,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e           state_q;
  logic [3:0]       vec_q;
  logic [7:0]       cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       ffv_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [1:0]       a_val;
  logic [1:0]       b_val;
  logic [2:0]       exp_f;
  logic             mismatch;
  logic             sample;

  // Expected comparator response, mismatch detect and saturating error increment
  always_comb begin
    a_val    = vec_q[3:2];
    b_val    = vec_q[1:0];
    exp_f    = {a_val > b_val, a_val == b_val, a_val < b_val};
    mismatch = ({F1, F2, F3} != exp_f);
    sample   = (cnt_q == DWELL_LAST);
    err_d    = (err_q == '1) ? err_q : err_q + ERR_W'(1);
  end

  // Sweep FSM with registered status and stimulus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffv_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (sample) begin
            if (mismatch) begin
              err_q <= err_d;
              if (err_q == '0) begin
                ffv_q <= vec_q;
              end
            end
`ifdef CMP_STOP_ON_FAIL_EN
            if (mismatch || (vec_q == 4'hF)) begin
`else
            if (vec_q == 4'hF) begin
`endif
              // Stimulus keeps the last presented vector while in DONE
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_q == '0) && !mismatch;
              cnt_q   <= '0;
            end else begin
              vec_q <= vec_q + 4'd1;
              cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign {A1, A0, B1, B0} = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;

endmodule

// File: tb/tb_comparator_2b_checker.sv
// Bench for comparator_2b_checker: two instances (DWELL=4 and DWELL=1) driven by
// a configurable comparator model, checked every cycle against a timeline model.
module tb_comparator_2b_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  int         fault;

  logic [1:0] a1, a0, b1, b0, busy, done, pass;
  logic [4:0] err[2];
  logic [3:0] ffv[2];
  logic [2:0] f[2];

  int total = 0;
  int bad   = 0;

  // model state per instance
  bit m_act[2];
  int m_k[2];
  int m_mode[2];

  comparator_2b_checker #(.DWELL(4), .ERR_W(5)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .F1(f[0][2]), .F2(f[0][1]), .F3(f[0][0]),
    .A1(a1[0]), .A0(a0[0]), .B1(b1[0]), .B0(b0[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .first_fail_vec(ffv[0])
  );

  comparator_2b_checker #(.DWELL(1), .ERR_W(5)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .F1(f[1][2]), .F2(f[1][1]), .F3(f[1][0]),
    .A1(a1[1]), .A0(a0[1]), .B1(b1[1]), .B0(b0[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .first_fail_vec(ffv[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Comparator under test: 0 correct, 1 F2 stuck at 0, 2 F1/F3 swapped
  function automatic logic [2:0] resp(input int v, input int mode);
    int  a, b;
    logic gt, eq, lt;
    a  = v / 4;
    b  = v % 4;
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
    case (mode)
      1:       return {gt, 1'b0, lt};
      2:       return {lt, eq, gt};
      default: return {gt, eq, lt};
    endcase
  endfunction

  function automatic bit vfail(input int v, input int mode);
    return resp(v, mode) != resp(v, 0);
  endfunction

  function automatic int last_vec(input int mode);
`ifdef CMP_STOP_ON_FAIL_EN
    for (int v = 0; v < 16; v++) if (vfail(v, mode)) return v;
`endif
    return 15;
  endfunction

  function automatic int busy_len(input int i, input int mode);
    return (last_vec(mode) + 1) * dw(i);
  endfunction

  always_comb begin
    f[0] = resp(int'({a1[0], a0[0], b1[0], b0[0]}), fault);
    f[1] = resp(int'({a1[1], a0[1], b1[1], b0[1]}), fault);
  end

  // Timeline model: k counts cycles since the accepted start (k=1 first busy cycle)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
        m_mode[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start && !(m_act[i] && m_k[i] <= busy_len(i, m_mode[i]))) begin
          m_act[i]  <= 1'b1;
          m_k[i]    <= 1;
          m_mode[i] <= fault;
        end else if (m_act[i] && m_k[i] <= busy_len(i, m_mode[i])) begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int  l, blen, k, ns, e, fv, v_exp;
      bit  b_exp, d_exp, p_exp;
      b_exp = 0; d_exp = 0; p_exp = 0; e = 0; fv = 0; v_exp = 0;
      if (m_act[i]) begin
        k     = m_k[i];
        l     = last_vec(m_mode[i]);
        blen  = (l + 1) * dw(i);
        b_exp = (k <= blen);
        d_exp = !b_exp;
        v_exp = b_exp ? (k - 1) / dw(i) : l;
        ns    = (k - 1) / dw(i);
        if (ns > l + 1) ns = l + 1;
        for (int v = 0; v < ns; v++) begin
          if (vfail(v, m_mode[i])) begin
            if (e == 0) fv = v;
            e++;
          end
        end
        if (e > 31) e = 31;
        p_exp = d_exp && (e == 0);
      end
      chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(b_exp));
      chk($sformatf("done[%0d]", i), int'(done[i]), int'(d_exp));
      chk($sformatf("pass[%0d]", i), int'(pass[i]), int'(p_exp));
      chk($sformatf("err[%0d]", i), int'(err[i]), e);
      chk($sformatf("ffv[%0d]", i), int'(ffv[i]), fv);
      chk($sformatf("vec[%0d]", i), int'({a1[i], a0[i], b1[i], b0[i]}), v_exp);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int j = 0; j < n; j++) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_out[%0d]", tag, i),
          int'({a1[i], a0[i], b1[i], b0[i], busy[i], done[i], pass[i]}), 0);
      chk($sformatf("%s_err[%0d]", tag, i), int'(err[i]), 0);
      chk($sformatf("%s_ffv[%0d]", tag, i), int'(ffv[i]), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fault = 0;
    #7;
    chk_zero("rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_neg(6);

    // Correct comparator: busy 64 cycles, done at N+65; DWELL=1 done at N+17
    pulse_start();
    chk("d4_busy_first", int'(busy[0]), 1);
    chk("d4_vec_first", int'({a1[0], a0[0], b1[0], b0[0]}), 0);
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      if (j == 1)  chk("d1_vec_step", int'({a1[1], a0[1], b1[1], b0[1]}), 1);
      if (j == 15) chk("d1_done_early", int'(done[1]), 0);
      if (j == 16) begin
        chk("d1_done", int'(done[1]), 1);
        chk("d1_pass", int'(pass[1]), 1);
      end
      if (j == 63) begin
        chk("d4_busy_last", int'(busy[0]), 1);
        chk("d4_done_early", int'(done[0]), 0);
      end
      if (j == 64) begin
        chk("d4_done", int'(done[0]), 1);
        chk("d4_busy_off", int'(busy[0]), 0);
        chk("d4_pass", int'(pass[0]), 1);
        chk("d4_err", int'(err[0]), 0);
        chk("d4_hold15", int'({a1[0], a0[0], b1[0], b0[0]}), 15);
      end
    end

    // F2 stuck at 0
    fault = 1;
    pulse_start();
    wait_neg(70);
`ifdef CMP_STOP_ON_FAIL_EN
    chk("f2_err", int'(err[0]), 1);
    chk("f2_hold", int'({a1[0], a0[0], b1[0], b0[0]}), 0);
`else
    chk("f2_err", int'(err[0]), 4);
`endif
    chk("f2_ffv", int'(ffv[0]), 0);
    chk("f2_pass", int'(pass[0]), 0);

    // F1/F3 swapped; restart from DONE clears results
    fault = 2;
    pulse_start();
    chk("restart_done", int'(done[0]), 0);
    chk("restart_err", int'(err[0]), 0);
    chk("restart_busy", int'(busy[0]), 1);
    wait_neg(70);
`ifdef CMP_STOP_ON_FAIL_EN
    chk("swap_err", int'(err[0]), 1);
`else
    chk("swap_err", int'(err[0]), 12);
`endif
    chk("swap_ffv", int'(ffv[0]), 1);
    chk("swap_pass", int'(pass[0]), 0);

    // Asynchronous reset while vector 5 is presented
    fault = 0;
    pulse_start();
    wait_neg(21);
    chk("pre_rst_vec5", int'({a1[0], a0[0], b1[0], b0[0]}), 5);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulse_start();
    wait_neg(64);
    chk("post_rst_done", int'(done[0]), 1);
    chk("post_rst_pass", int'(pass[0]), 1);

    // Start while busy at vector 3 is ignored
    pulse_start();
    wait_neg(13);
    chk("busy_v3", int'({a1[0], a0[0], b1[0], b0[0]}), 3);
    pulse_start();
    wait_neg(48);
    chk("ign_busy", int'(busy[0]), 1);
    chk("ign_done_early", int'(done[0]), 0);
    @(negedge clk);
    chk("ign_done", int'(done[0]), 1);
    chk("ign_pass", int'(pass[0]), 1);
    wait_neg(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
